// File: rtl/weight_updater_pkg.sv
// Shared constants, FSM encoding and weight-address packing for the learning path
// (used by the count muxer, lookup tables and the weight updater).
package weight_updater_pkg;

  localparam int M   = 784;
  localparam int N   = 16;
  localparam int W   = 24;
  localparam int LAT = 2;
  localparam int AW  = 14;
  localparam int IW  = 10;
  localparam int NW  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FLUSH = 2'd2
  } wu_state_t;

  function automatic logic [AW-1:0] make_addr(input logic [NW-1:0] neuron,
                                              input logic [IW-1:0] idx);
    return {neuron, idx};
  endfunction

endpackage

// File: rtl/weight_updater_sat_accum.sv
// Combinational saturating w + plus - minus, clamped to the unsigned WIDTH-bit range.
module sat_accum
  import weight_updater_pkg::*;
#(
  parameter int WIDTH = W
) (
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] plus,
  input  logic [WIDTH-1:0] minus,
  output logic [WIDTH-1:0] result
);

  logic signed [WIDTH+1:0] sum;

  // Two guard bits: the top one flags a negative result, the next an overflow.
  always_comb begin
    sum    = $signed({2'b00, w}) + $signed({2'b00, plus}) - $signed({2'b00, minus});
    result = sum[WIDTH-1:0];
    if (sum[WIDTH+1]) begin
      result = '0;
    end else if (sum[WIDTH]) begin
      result = '1;
    end
  end

endmodule

// File: rtl/weight_updater.sv
// Read-modify-write engine that applies the delta stream to the weights of the
// neuron that won, one input per cycle, with saturating arithmetic.
module weight_updater
  import weight_updater_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  start_wch,
  input  logic [IW-1:0] ip_select,
  input  logic [W-1:0]  del_w_plus,
  input  logic [W-1:0]  del_w_minus,
  output logic          w_rd_en,
  output logic [AW-1:0] w_rd_addr,
  input  logic [W-1:0]  w_rd_data,
  output logic          w_wr_en,
  output logic [AW-1:0] w_wr_addr,
  output logic [W-1:0]  w_wr_data,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  wu_state_t     state_q, state_d;
  logic [NW-1:0] neuron_q, first_set;
  logic [IW-1:0] sel_sr [LAT];
  logic [IW-1:0] d_sel;
  logic          start_any, start_prev, start_rise;
  logic          capture, latch_neuron, finish;
  logic [W-1:0]  s1_plus, s1_minus;
  logic          s1_last;
  logic          p_valid, p_last;
  logic [AW-1:0] p_addr;
  logic [W-1:0]  p_plus, p_minus;
  logic          wr_last;
  logic [W-1:0]  new_w;

  assign start_any  = |start_wch;
  assign start_rise = start_any && !start_prev;
  assign d_sel      = sel_sr[LAT-1];
  assign busy       = (state_q != IDLE) || done;

  // Lowest-numbered winner has priority when several strobes are set.
  always_comb begin
    first_set = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (start_wch[i]) first_set = NW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    latch_neuron = 1'b0;
    finish       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_any) begin
          state_d      = SWEEP;
          latch_neuron = 1'b1;
        end
      end
      SWEEP: begin
        if (d_sel != '0) begin
          capture = 1'b1;
          if (d_sel == IW'(M - 1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (w_wr_en && wr_last) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      neuron_q   <= '0;
      start_prev <= 1'b0;
      overrun    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_prev <= start_any;
      done       <= finish;
      if (latch_neuron) neuron_q <= first_set;
      if (start_rise && state_q != IDLE) overrun <= 1'b1;
    end
  end

  // Delays ip_select so each index lines up with its delta.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_sr <= '{default: '0};
    end else begin
      sel_sr[0] <= ip_select;
      for (int i = 1; i < LAT; i++) sel_sr[i] <= sel_sr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_rd_en   <= 1'b0;
      w_rd_addr <= '0;
      s1_plus   <= '0;
      s1_minus  <= '0;
      s1_last   <= 1'b0;
    end else begin
      w_rd_en <= capture;
      if (capture) begin
        w_rd_addr <= make_addr(neuron_q, d_sel);
        s1_plus   <= del_w_plus;
        s1_minus  <= del_w_minus;
        s1_last   <= (d_sel == IW'(M - 1));
      end
    end
  end

  // Deltas wait here for the RAM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_addr  <= '0;
      p_plus  <= '0;
      p_minus <= '0;
      p_last  <= 1'b0;
    end else begin
      p_valid <= w_rd_en;
      p_addr  <= w_rd_addr;
      p_plus  <= s1_plus;
      p_minus <= s1_minus;
      p_last  <= s1_last;
    end
  end

  sat_accum #(.WIDTH(W)) u_sat (
    .w      (w_rd_data),
    .plus   (p_plus),
    .minus  (p_minus),
    .result (new_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      w_wr_en   <= 1'b0;
      w_wr_addr <= '0;
      w_wr_data <= '0;
      wr_last   <= 1'b0;
    end else begin
      w_wr_en <= p_valid;
      wr_last <= p_valid && p_last;
      if (p_valid) begin
        w_wr_addr <= p_addr;
        w_wr_data <= new_w;
      end
    end
  end

endmodule

// File: tb/tb_weight_updater.sv
// Scoreboard bench: acts as the upstream sweep and the weight RAM, predicts every
// write from a shadow copy of the weights and checks busy/done/overrun per cycle.
module tb_weight_updater;
  import weight_updater_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  start_wch;
  logic [IW-1:0] ip_select;
  logic [W-1:0]  del_w_plus, del_w_minus;
  logic          w_rd_en, w_wr_en;
  logic [AW-1:0] w_rd_addr, w_wr_addr;
  logic [W-1:0]  w_rd_data, w_wr_data;
  logic          busy, done, overrun;

  always #5 clk = ~clk;

  weight_updater dut (
    .clk         (clk),
    .rst         (rst),
    .start_wch   (start_wch),
    .ip_select   (ip_select),
    .del_w_plus  (del_w_plus),
    .del_w_minus (del_w_minus),
    .w_rd_en     (w_rd_en),
    .w_rd_addr   (w_rd_addr),
    .w_rd_data   (w_rd_data),
    .w_wr_en     (w_wr_en),
    .w_wr_addr   (w_wr_addr),
    .w_wr_data   (w_wr_data),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    int            cyc;
  } exp_wr_t;

  logic [W-1:0]  mem    [0:(1<<AW)-1];
  logic [W-1:0]  shadow [0:(1<<AW)-1];
  exp_wr_t       sb[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc;
  int            exp_done;
  int            done_seen;
  logic          m_overrun;
  logic          hold_rd_en, hold_wr_en;
  logic [AW-1:0] hold_rd_addr, hold_wr_addr;
  logic [W-1:0]  hold_wr_data;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] satModel(input logic [W-1:0] w, input logic [W-1:0] p,
                                            input logic [W-1:0] m);
    longint v;
    v = longint'(w) + longint'(p) - longint'(m);
    if (v < 0) return '0;
    if (v > (longint'(1) << W) - 1) return '1;
    return W'(v);
  endfunction

  // Upstream sweep index for cycle c; a restart begins a fresh sweep, reset silences it.
  function automatic int ipAt(input int c, input int restart_cyc, input int rst_cyc);
    int idx;
    if (c < 1) return 0;
    if (rst_cyc != 0 && c > rst_cyc) return 0;
    idx = (restart_cyc != 0 && c > restart_cyc) ? c - restart_cyc : c;
    return (idx >= 1 && idx <= M - 1) ? idx : 0;
  endfunction

  task automatic getDelta(input int mode, input int idx, output logic [W-1:0] p,
                          output logic [W-1:0] m);
    case (mode)
      0:       begin p = W'(5);   m = '0; end
      1:       begin p = (idx % 2 == 1) ? W'(10) : '0; m = (idx % 2 == 1) ? '0 : W'(9); end
      2:       begin p = W'(idx); m = '0; end
      default: begin p = W'(idx % 7); m = W'(idx % 3); end
    endcase
  endtask

  task automatic initWeights(input int neuron, input int mode);
    logic [AW-1:0] a;
    for (int i = 0; i < (1 << IW); i++) begin
      a = make_addr(NW'(neuron), IW'(i));
      case (mode)
        0:       mem[a] = W'(100);
        1:       mem[a] = (i % 2 == 1) ? W'((1 << W) - 3) : W'(4);
        2:       mem[a] = W'(1000 + 3 * i);
        default: mem[a] = W'(50);
      endcase
      shadow[a] = mem[a];
    end
  endtask

  task automatic stepCycle(input int rst_cyc);
    exp_wr_t e;
    logic    busy_exp;
    @(negedge clk);
    busy_exp = (cyc >= 1) &&
               ((exp_done >= 0) ? (cyc <= exp_done) : (rst_cyc == 0 || cyc <= rst_cyc));
    checkOutput("busy", busy, busy_exp);
    checkOutput("overrun", overrun, m_overrun);
    if (w_wr_en) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", w_wr_addr, -1);
      end else begin
        e = sb.pop_front();
        checkOutput("wr_addr", w_wr_addr, e.addr);
        checkOutput("wr_data", w_wr_data, e.data);
        checkOutput("wr_cycle", cyc, e.cyc);
      end
    end
    if (done) begin
      done_seen++;
      checkOutput("done_cycle", cyc, exp_done);
    end
    hold_rd_en   = w_rd_en;
    hold_rd_addr = w_rd_addr;
    hold_wr_en   = w_wr_en;
    hold_wr_addr = w_wr_addr;
    hold_wr_data = w_wr_data;
    @(posedge clk);
    #1;
    cyc++;
    w_rd_data = hold_rd_en ? mem[hold_rd_addr] : W'($urandom);
    if (hold_wr_en) mem[hold_wr_addr] = hold_wr_data;
  endtask

  // One start event from cycle 0, optional second start and optional reset.
  task automatic applyStimulus(input logic [N-1:0] mask, input int neuron, input int mode,
                               input int restart_cyc, input logic [N-1:0] restart_mask,
                               input int rst_cyc, input int exp_done_count);
    int            dsel;
    bit            active, finished;
    logic [W-1:0]  p, m;
    logic [AW-1:0] a;
    exp_wr_t       e;
    cyc       = 0;
    exp_done  = -1;
    done_seen = 0;
    active    = 1'b1;
    finished  = 1'b0;
    for (int k = 0; k < 2000 && !finished; k++) begin
      if (restart_cyc != 0 && cyc == restart_cyc + 1) m_overrun = 1'b1;
      if (rst_cyc != 0 && cyc == rst_cyc + 1) m_overrun = 1'b0;
      start_wch = (cyc == 0) ? mask : ((restart_cyc != 0 && cyc == restart_cyc) ? restart_mask : '0);
      rst       = (rst_cyc != 0 && cyc == rst_cyc);
      ip_select = IW'(ipAt(cyc, restart_cyc, rst_cyc));
      dsel      = ipAt(cyc - LAT, restart_cyc, rst_cyc);
      if (dsel == 0) begin
        p = W'($urandom_range(1000));
        m = W'($urandom_range(1000));
      end else begin
        getDelta(mode, dsel, p, m);
      end
      del_w_plus  = p;
      del_w_minus = m;
      if (active && dsel != 0) begin
        if (rst_cyc != 0 && cyc + 3 > rst_cyc) begin
          active = 1'b0;
        end else begin
          a         = make_addr(NW'(neuron), IW'(dsel));
          e.addr    = a;
          e.data    = satModel(shadow[a], p, m);
          e.cyc     = cyc + 3;
          shadow[a] = e.data;
          sb.push_back(e);
          if (dsel == M - 1) begin
            active   = 1'b0;
            exp_done = cyc + 4;
          end
        end
      end
      stepCycle(rst_cyc);
      if (exp_done >= 0 && cyc > exp_done + 2) finished = 1'b1;
      if (rst_cyc != 0 && cyc > rst_cyc + 10) finished = 1'b1;
    end
    rst = 1'b0;
    if (!finished) checkOutput("timeout", 1, 0);
    checkOutput("done_count", done_seen, exp_done_count);
    checkOutput("pending_writes", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    rst         = 1'b1;
    start_wch   = '0;
    ip_select   = '0;
    del_w_plus  = '0;
    del_w_minus = '0;
    w_rd_data   = '0;
    m_overrun   = 1'b0;
    cyc         = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = W'(7);
      shadow[i] = W'(7);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_rd_en", w_rd_en, 0);
    checkOutput("reset_wr_en", w_wr_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] potentiation on neuron 2");
    initWeights(2, 0);
    applyStimulus(16'h0004, 2, 0, 0, '0, 0, 1);
    checkOutput("input0_untouched", mem[make_addr(4'd2, 10'd0)], 100);
    checkOutput("last_weight", mem[make_addr(4'd2, 10'd783)], 105);

    $display("[TB] saturation on neuron 0");
    initWeights(0, 1);
    applyStimulus(16'h0001, 0, 1, 0, '0, 0, 1);
    checkOutput("sat_high", mem[make_addr(4'd0, 10'd1)], (1 << W) - 1);
    checkOutput("sat_low", mem[make_addr(4'd0, 10'd2)], 0);

    $display("[TB] multi-hot start picks neuron 4");
    initWeights(4, 3);
    applyStimulus(16'h8010, 4, 3, 0, '0, 0, 1);
    checkOutput("neuron15_untouched", mem[make_addr(4'd15, 10'd5)], 7);

    $display("[TB] overrun with restart at cycle 300");
    initWeights(3, 3);
    applyStimulus(16'h0008, 3, 3, 300, 16'h0001, 0, 1);

    $display("[TB] reset mid-sweep at cycle 400");
    initWeights(5, 2);
    applyStimulus(16'h0020, 5, 2, 0, '0, 400, 0);

    $display("[TB] alignment sweep after reset");
    applyStimulus(16'h0020, 5, 2, 0, '0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
